syn_fpga_status_ctrl: RTL and testbench

Parametrised board status and display controller for the Synesthesia Zen FPGA top, on the 50 MHz cortex clock domain.
- Replaces the hard-wired seven-segment blanking and LED status assigns with a local-bus programmable block.
- Drives P_NUM_HEX seven-segment digits (hex-decoded, per-digit blank and blink) plus green and red LEDs.
- Synchronises asynchronous status lines (PLL lock loss, domain resets, faults), shows them live on the top red LEDs and latches sticky copies that software reads and clears.

---
 rtl/syn_fpga_status_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_syn_fpga_status_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_fpga_status_ctrl.sv
// Board status and display controller: local-bus registers driving seven-segment digits,
// green/red LEDs, plus synchronised live and sticky status lines with a shared blink phase.
module syn_fpga_status_ctrl #(
    parameter int P_LB_DWIDTH  = 32,
    parameter int P_LB_AWIDTH  = 8,
    parameter int P_NUM_HEX    = 4,
    parameter int P_NUM_LEDR   = 10,
    parameter int P_NUM_LEDG   = 8,
    parameter int P_NUM_STATUS = 3,
    parameter int P_BLINK_DIV  = 25000000
) (
    input  logic                     clk_ir,
    input  logic                     rst_il,
    input  logic                     lb_wr_en_i,
    input  logic                     lb_rd_en_i,
    input  logic [P_LB_AWIDTH-1:0]   lb_addr_i,
    input  logic [P_LB_DWIDTH-1:0]   lb_wr_data_i,
    output logic                     lb_rd_valid_o,
    output logic [P_LB_DWIDTH-1:0]   lb_rd_data_o,
    input  logic [P_NUM_STATUS-1:0]  status_i,
    output logic [7*P_NUM_HEX-1:0]   hex_o,
    output logic [P_NUM_LEDR-1:0]    ledr_o,
    output logic [P_NUM_LEDG-1:0]    ledg_o
);

    localparam int CNT_W = (P_BLINK_DIV > 2) ? $clog2(P_BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_BLINK_DIV - 1);
    // Software-owned red LEDs are the ones below the status LEDs.
    localparam logic [P_NUM_LEDR-1:0] LEDR_SW_MASK = {P_NUM_LEDR{1'b1}} >> P_NUM_STATUS;

    localparam logic [2:0] A_CTRL      = 3'd0;
    localparam logic [2:0] A_HEX_VAL   = 3'd1;
    localparam logic [2:0] A_HEX_BLANK = 3'd2;
    localparam logic [2:0] A_HEX_BLINK = 3'd3;
    localparam logic [2:0] A_LEDG      = 3'd4;
    localparam logic [2:0] A_LEDR_SW   = 3'd5;
    localparam logic [2:0] A_STATUS    = 3'd6;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0e;
        endcase
        return s;
    endfunction

    logic [1:0]               ctrl_q;
    logic [4*P_NUM_HEX-1:0]   hex_val_q;
    logic [P_NUM_HEX-1:0]     hex_blank_q;
    logic [P_NUM_HEX-1:0]     hex_blink_q;
    logic [P_NUM_LEDG-1:0]    ledg_q;
    logic [P_NUM_LEDR-1:0]    ledr_sw_q;
    logic [P_NUM_STATUS-1:0]  sync_p0;
    logic [P_NUM_STATUS-1:0]  sync_p1;
    logic [P_NUM_STATUS-1:0]  sticky_q;
    logic [CNT_W-1:0]         blink_cnt_q;
    logic                     blink_phase_q;
    logic                     rd_vld_p0;
    logic [P_LB_DWIDTH-1:0]   rd_data_p0;

    logic [2:0]               reg_sel;
    logic                     wr_status;
    logic [P_NUM_STATUS-1:0]  sticky_clr;
    logic [P_LB_DWIDTH-1:0]   rd_mux;
    logic [7*P_NUM_HEX-1:0]   hex_d;
    logic [P_NUM_LEDR-1:0]    ledr_d;
    logic                     unused_lb;

    assign reg_sel    = lb_addr_i[2:0];
    assign wr_status  = lb_wr_en_i && (reg_sel == A_STATUS);
    assign sticky_clr = wr_status ? lb_wr_data_i[P_NUM_STATUS-1:0] : '0;
    assign unused_lb  = ^{lb_addr_i, lb_wr_data_i};

    // Register file
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            ctrl_q      <= '0;
            hex_val_q   <= '0;
            hex_blank_q <= '1;
            hex_blink_q <= '0;
            ledg_q      <= '0;
            ledr_sw_q   <= '0;
        end else if (lb_wr_en_i) begin
            case (reg_sel)
                A_CTRL:      ctrl_q      <= lb_wr_data_i[1:0];
                A_HEX_VAL:   hex_val_q   <= lb_wr_data_i[4*P_NUM_HEX-1:0];
                A_HEX_BLANK: hex_blank_q <= lb_wr_data_i[P_NUM_HEX-1:0];
                A_HEX_BLINK: hex_blink_q <= lb_wr_data_i[P_NUM_HEX-1:0];
                A_LEDG:      ledg_q      <= lb_wr_data_i[P_NUM_LEDG-1:0];
                A_LEDR_SW:   ledr_sw_q   <= lb_wr_data_i[P_NUM_LEDR-1:0] & LEDR_SW_MASK;
                default: ;
            endcase
        end
    end

    // Status synchroniser and sticky latch; a set in the same cycle as a clear wins
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            sticky_q <= '0;
        end else begin
            sync_p0  <= status_i;
            sync_p1  <= sync_p0;
            sticky_q <= (sticky_q & ~sticky_clr) | sync_p1;
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (!ctrl_q[1]) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            A_CTRL:      rd_mux[1:0]             = ctrl_q;
            A_HEX_VAL:   rd_mux[4*P_NUM_HEX-1:0] = hex_val_q;
            A_HEX_BLANK: rd_mux[P_NUM_HEX-1:0]   = hex_blank_q;
            A_HEX_BLINK: rd_mux[P_NUM_HEX-1:0]   = hex_blink_q;
            A_LEDG:      rd_mux[P_NUM_LEDG-1:0]  = ledg_q;
            A_LEDR_SW:   rd_mux[P_NUM_LEDR-1:0]  = ledr_sw_q;
            A_STATUS: begin
                rd_mux[P_NUM_STATUS-1:0]              = sticky_q;
                rd_mux[2*P_NUM_STATUS-1:P_NUM_STATUS] = sync_p1;
            end
            default: ;
        endcase
    end

    // Read stage p0: capture pre-write register contents
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            rd_vld_p0  <= 1'b0;
            rd_data_p0 <= '0;
        end else begin
            rd_vld_p0 <= lb_rd_en_i;
            if (lb_rd_en_i) rd_data_p0 <= rd_mux;
        end
    end

    // Read stage p1: bus output
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            lb_rd_valid_o <= 1'b0;
            lb_rd_data_o  <= '0;
        end else begin
            lb_rd_valid_o <= rd_vld_p0;
            if (rd_vld_p0) lb_rd_data_o <= rd_data_p0;
        end
    end

    always_comb begin
        hex_d = '1;
        for (int d = 0; d < P_NUM_HEX; d++) begin
            if (ctrl_q[0] && !hex_blank_q[d] &&
                !(ctrl_q[1] && hex_blink_q[d] && blink_phase_q))
                hex_d[7*d +: 7] = hex_seg(hex_val_q[4*d +: 4]);
        end
    end

    // Status LEDs: live is steady on, sticky-only follows the blink phase
    always_comb begin
        ledr_d = ledr_sw_q;
        for (int s = 0; s < P_NUM_STATUS; s++)
            ledr_d[P_NUM_LEDR-P_NUM_STATUS+s] = sync_p1[s] | (sticky_q[s] & blink_phase_q);
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            hex_o  <= '1;
            ledr_o <= '0;
            ledg_o <= '0;
        end else begin
            hex_o  <= hex_d;
            ledr_o <= ledr_d;
            ledg_o <= ledg_q;
        end
    end

endmodule

// File: tb/tb_syn_fpga_status_ctrl.sv
// Randomised bench for syn_fpga_status_ctrl against a cycle-level behavioural model,
// with directed sequences for reset, decoding, sticky status and blink behaviour.
module tb_syn_fpga_status_ctrl;

    localparam int DIV = 4;

    logic        clk_ir = 1'b0;
    logic        rst_il;
    logic        lb_wr_en_i;
    logic        lb_rd_en_i;
    logic [7:0]  lb_addr_i;
    logic [31:0] lb_wr_data_i;
    logic        lb_rd_valid_o;
    logic [31:0] lb_rd_data_o;
    logic [2:0]  status_i;
    logic [27:0] hex_o;
    logic [9:0]  ledr_o;
    logic [7:0]  ledg_o;

    syn_fpga_status_ctrl #(.P_BLINK_DIV(DIV)) dut (
        .clk_ir(clk_ir), .rst_il(rst_il),
        .lb_wr_en_i(lb_wr_en_i), .lb_rd_en_i(lb_rd_en_i),
        .lb_addr_i(lb_addr_i), .lb_wr_data_i(lb_wr_data_i),
        .lb_rd_valid_o(lb_rd_valid_o), .lb_rd_data_o(lb_rd_data_o),
        .status_i(status_i), .hex_o(hex_o), .ledr_o(ledr_o), .ledg_o(ledg_o)
    );

    always #5 clk_ir = ~clk_ir;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    // Model state: register contents, status history and count of consecutive blink-enabled edges
    logic [31:0] m_ctrl, m_hex_val, m_blank, m_blink, m_ledg, m_ledr_sw;
    logic [2:0]  m_sticky, m_live, m_prev;
    int          m_en_cnt;
    logic        m_p_vld;
    logic [31:0] m_p_data;
    logic [27:0] exp_hex;
    logic [9:0]  exp_ledr;
    logic [7:0]  exp_ledg;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [2:0]  st_drv;

    task automatic model_reset();
        m_ctrl = 0; m_hex_val = 0; m_blank = 32'hf; m_blink = 0; m_ledg = 0; m_ledr_sw = 0;
        m_sticky = 0; m_live = 0; m_prev = 0; m_en_cnt = 0; m_p_vld = 0; m_p_data = 0;
        exp_vld = 0; exp_data = 0;
    endtask

    function automatic logic [27:0] model_hex(input logic ph);
        logic [27:0] h;
        logic [3:0]  nib;
        h = '1;
        for (int d = 0; d < 4; d++) begin
            nib = 4'((m_hex_val >> (4 * d)) & 32'hf);
            if (m_ctrl[0] && !m_blank[d] && !(m_ctrl[1] && m_blink[d] && ph))
                h[7*d +: 7] = font[nib];
        end
        return h;
    endfunction

    function automatic logic [9:0] model_ledr(input logic ph);
        logic [9:0] l;
        l = m_ledr_sw[9:0] & 10'h07f;
        for (int s = 0; s < 3; s++)
            l[7+s] = m_live[s] ? 1'b1 : (m_sticky[s] ? ph : 1'b0);
        return l;
    endfunction

    function automatic logic [31:0] read_map(input logic [2:0] a);
        case (a)
            3'd0: return m_ctrl;
            3'd1: return m_hex_val;
            3'd2: return m_blank;
            3'd3: return m_blink;
            3'd4: return m_ledg;
            3'd5: return m_ledr_sw;
            3'd6: return {26'd0, m_live, m_sticky};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic wr, input logic rd, input logic [7:0] addr,
                              input logic [31:0] data);
        logic [2:0] a;
        logic       ph;
        logic       blink_on;
        logic [2:0] clr;
        a  = addr[2:0];
        ph = ((m_en_cnt / DIV) % 2) == 1;
        exp_hex  = model_hex(ph);
        exp_ledr = model_ledr(ph);
        exp_ledg = m_ledg[7:0];
        exp_vld  = m_p_vld;
        if (m_p_vld) exp_data = m_p_data;
        m_p_vld = rd;
        if (rd) m_p_data = read_map(a);
        blink_on = m_ctrl[1];
        clr = (wr && a == 3'd6) ? data[2:0] : 3'd0;
        if (wr) begin
            case (a)
                3'd0: m_ctrl    = data & 32'h3;
                3'd1: m_hex_val = data & 32'hffff;
                3'd2: m_blank   = data & 32'hf;
                3'd3: m_blink   = data & 32'hf;
                3'd4: m_ledg    = data & 32'hff;
                3'd5: m_ledr_sw = data & 32'h7f;
                default: ;
            endcase
        end
        m_sticky = (m_sticky & ~clr) | m_live;
        m_live   = m_prev;
        m_prev   = st_drv;
        m_en_cnt = blink_on ? m_en_cnt + 1 : 0;
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [31:0] data);
        lb_wr_en_i = wr; lb_rd_en_i = rd; lb_addr_i = addr; lb_wr_data_i = data;
        status_i = st_drv;
        @(posedge clk_ir);
        model_step(wr, rd, addr, data);
        #1;
        check("hex_o", {36'd0, hex_o}, {36'd0, exp_hex});
        check("ledr_o", {54'd0, ledr_o}, {54'd0, exp_ledr});
        check("ledg_o", {56'd0, ledg_o}, {56'd0, exp_ledg});
        check("rd_valid", {63'd0, lb_rd_valid_o}, {63'd0, exp_vld});
        if (exp_vld) check("rd_data", {32'd0, lb_rd_data_o}, {32'd0, exp_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
        cycle(1'b1, 1'b0, addr, data);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        cycle(1'b0, 1'b1, addr, 32'd0);
        idle(1);
        check(tag, {63'd0, lb_rd_valid_o}, 64'd1);
        check(tag, {32'd0, lb_rd_data_o}, {32'd0, exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"}, {36'd0, hex_o}, {36'd0, 28'hfffffff});
        check({tag, "_ledr"}, {54'd0, ledr_o}, 64'd0);
        check({tag, "_ledg"}, {56'd0, ledg_o}, 64'd0);
        check({tag, "_vld"}, {63'd0, lb_rd_valid_o}, 64'd0);
        check({tag, "_data"}, {32'd0, lb_rd_data_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        rst_il = 1'b0; lb_wr_en_i = 0; lb_rd_en_i = 0; lb_addr_i = 0; lb_wr_data_i = 0;
        status_i = 0; st_drv = 0;
        model_reset();
        repeat (3) @(posedge clk_ir);
        #1;
        check_reset_outputs("reset");
        rst_il = 1'b1;

        idle(2);
        read_expect("rd_blank_rst", 8'd2, 32'h0000000f);

        wr_reg(8'd0, 32'h1);
        wr_reg(8'd2, 32'h0);
        wr_reg(8'd1, 32'h0000A180);
        idle(1);
        check("hex_a180", {36'd0, hex_o}, {36'd0, 7'h08, 7'h79, 7'h00, 7'h40});

        st_drv = 3'b010;
        idle(2);
        st_drv = 3'b000;
        idle(4);
        read_expect("sticky1", 8'd6, 32'h2);
        wr_reg(8'd0, 32'h3);
        idle(13);
        wr_reg(8'd6, 32'h2);
        idle(1);
        check("ledr8_clr", {63'd0, ledr_o[8]}, 64'd0);
        read_expect("sticky1_clr", 8'd6, 32'h0);

        st_drv = 3'b001;
        idle(4);
        wr_reg(8'd6, 32'h1);
        idle(2);
        check("ledr7_setwins", {63'd0, ledr_o[7]}, 64'd1);
        read_expect("sticky0_setwins", 8'd6, 32'h9);
        st_drv = 3'b000;
        idle(3);
        wr_reg(8'd6, 32'h7);

        wr_reg(8'd1, 32'h00004321);
        wr_reg(8'd3, 32'h1);
        idle(17);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) st_drv[$urandom_range(0, 2)] ^= 1'b1;
            a = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a[7:3] = 5'($urandom);
            d = $urandom;
            if (a[2:0] == 3'd2 && $urandom_range(0, 2) != 0) d &= 32'h5;
            if (a[2:0] == 3'd0 && $urandom_range(0, 3) != 0) d |= 32'h1;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, a, d);
        end

        st_drv = 3'b000;
        wr_reg(8'd0, 32'h3);
        st_drv = 3'b011;
        idle(4);
        st_drv = 3'b000;
        idle(7);
        rst_il = 1'b0;
        lb_wr_en_i = 0; lb_rd_en_i = 0; status_i = 0;
        #2;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(posedge clk_ir);
        #1;
        check_reset_outputs("held_reset");
        rst_il = 1'b1;
        idle(2);
        read_expect("sticky_after_rst", 8'd6, 32'h0);
        read_expect("ctrl_after_rst", 8'd0, 32'h0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
